// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative floating-point multiplier.
package fp_pkg;

  typedef enum logic [2:0] {IDLE, SPECIAL, MUL, NORM, DONE} state_t;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fclass_t;

  // Bit positions inside Flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
  function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/mcycle_shiftadd.sv
// Iterative unsigned multiplier retiring STEP multiplier bits per enabled cycle.
// The multiplier sits in the low half of the accumulator and shifts out as
// partial products are added into the high half.
module mcycle_shiftadd #(
  parameter int WIDTH = 24,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int ITER = (WIDTH + STEP - 1) / STEP;
  localparam int NB   = ITER * STEP;
  localparam int CW   = $clog2(ITER + 1);

  logic [WIDTH-1:0]      a_q;
  logic [WIDTH+NB-1:0]   acc;
  logic [CW-1:0]         cnt;
  logic [WIDTH+STEP-1:0] pp;
  logic [WIDTH+STEP-1:0] sum;

  // Partial product of the multiplicand with the next STEP multiplier bits
  always_comb begin
    pp  = {{STEP{1'b0}}, a_q} * {{WIDTH{1'b0}}, acc[STEP-1:0]};
    sum = {{STEP{1'b0}}, acc[WIDTH+NB-1:NB]} + pp;
  end

  assign last    = (cnt == CW'(ITER - 1));
  assign product = acc[2*WIDTH-1:0];

  // Accumulator and iteration counter; counter wraps after the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      a_q <= a;
      acc <= {{WIDTH{1'b0}}, NB'(b)};
      cnt <= '0;
    end else if (en) begin
      acc <= {sum, acc[NB-1:STEP]};
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fmul_iter.sv
// Iterative floating-point multiplier with FTZ, RNE/RTZ rounding, exception
// flags and a destination tag carried to writeback.
//
//   state   | meaning
//   IDLE    | waiting for Start
//   SPECIAL | zero/Inf/NaN operand, result resolved without multiplying
//   MUL     | shift-add significand product, STEP bits per cycle
//   NORM    | normalise, round, range check
//   DONE    | hand result to outputs; a new Start is accepted here
module fmul_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEP  = 1,
  parameter int TAG_W = 4
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 RoundMode,
  input  logic [EXP_W+MAN_W:0] Operand1,
  input  logic [EXP_W+MAN_W:0] Operand2,
  input  logic [TAG_W-1:0]     WA3,
  output logic [EXP_W+MAN_W:0] Result,
  output logic [3:0]           Flags,
  output logic                 Busy,
  output logic                 Done,
  output logic [TAG_W-1:0]     FMULWA3
);
  localparam int W    = EXP_W + MAN_W + 1;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = bias(EXP_W);
  localparam logic [W-1:0]  QNAN_VAL = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [XW-1:0] EXP_OVF  = XW'((1 << EXP_W) - 1);

  state_t state, state_nx;
  logic   load, step_en, last, special_in;
  logic [W-1:0]     op1_q, op2_q, res_q;
  logic [3:0]       flg_q;
  logic             rm_q;
  logic [TAG_W-1:0] tag_q;
  logic [PW-1:0]    prod;

  fclass_t c1, c2;
  logic          sign_p;
  logic [W-1:0]  spec_res, norm_res;
  logic [3:0]    spec_flg, norm_flg;
  logic [PW-2:0] prod_n;
  logic [MAN_W-1:0] frac_t;
  logic [MAN_W:0]   frac_r;
  logic          guard, sticky, rnd_inc, ovf, unf;
  logic [XW-1:0] exp_raw, exp_r;

  function automatic fclass_t classify(input logic [W-1:0] op);
    fclass_t c;
    if (op[W-2:MAN_W] == '0)      c = ZERO;
    else if (op[W-2:MAN_W] != '1) c = NORMAL;
    else if (op[MAN_W-1:0] == '0) c = INF;
    else if (op[MAN_W-1])         c = QNAN;
    else                          c = SNAN;
    return c;
  endfunction

  assign special_in = (classify(Operand1) != NORMAL) || (classify(Operand2) != NORMAL);
  assign Busy       = (state == SPECIAL) || (state == MUL) || (state == NORM);

  mcycle_shiftadd #(.WIDTH(MAN_W + 1), .STEP(STEP)) u_mul (
    .clk     (CLK),
    .rst_n   (Reset_n),
    .load    (load),
    .en      (step_en),
    .a       ({1'b1, Operand1[MAN_W-1:0]}),
    .b       ({1'b1, Operand2[MAN_W-1:0]}),
    .product (prod),
    .last    (last)
  );

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and multiplier control
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step_en  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (Start) begin
          load     = 1'b1;
          state_nx = special_in ? SPECIAL : MUL;
        end
      end
      SPECIAL: state_nx = DONE;
      MUL: begin
        step_en = 1'b1;
        if (last) state_nx = NORM;
      end
      NORM:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Special-operand result from the latched operands
  always_comb begin
    c1       = classify(op1_q);
    c2       = classify(op2_q);
    sign_p   = op1_q[W-1] ^ op2_q[W-1];
    spec_res = {sign_p, {(W-1){1'b0}}};
    spec_flg = '0;
    if (c1 == QNAN || c1 == SNAN || c2 == QNAN || c2 == SNAN) begin
      spec_res         = QNAN_VAL;
      spec_flg[FLG_NV] = (c1 == SNAN) || (c2 == SNAN);
    end else if ((c1 == INF && c2 == ZERO) || (c1 == ZERO && c2 == INF)) begin
      spec_res         = QNAN_VAL;
      spec_flg[FLG_NV] = 1'b1;
    end else if (c1 == INF || c2 == INF) begin
      spec_res = {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Normalise, round and range-check the significand product
  always_comb begin
    prod_n  = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac_t  = prod_n[PW-2:MAN_W+1];
    guard   = prod_n[MAN_W];
    sticky  = |prod_n[MAN_W-1:0];
    exp_raw = {2'b00, op1_q[W-2:MAN_W]} + {2'b00, op2_q[W-2:MAN_W]}
            - XW'(BIAS) + XW'(prod[PW-1]);
    rnd_inc = !rm_q && guard && (sticky || frac_t[0]);
    frac_r  = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_inc};
    exp_r   = exp_raw + XW'(frac_r[MAN_W]);
    ovf     = !exp_r[XW-1] && (exp_r >= EXP_OVF);
    unf     = exp_r[XW-1] || (exp_r == '0);
    norm_res = {sign_p, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    norm_flg = '0;
    norm_flg[FLG_NX] = guard | sticky;
    if (ovf) begin
      norm_res = rm_q ? {sign_p, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                      : {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flg[FLG_OF] = 1'b1;
      norm_flg[FLG_NX] = 1'b1;
    end else if (unf) begin
      norm_res = {sign_p, {(W-1){1'b0}}};
      norm_flg[FLG_UF] = 1'b1;
      norm_flg[FLG_NX] = 1'b1;
    end
  end

  // Operand capture, pending result, and output registers updated at DONE
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      op1_q   <= '0;
      op2_q   <= '0;
      rm_q    <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      Result  <= '0;
      Flags   <= '0;
      Done    <= 1'b0;
      FMULWA3 <= '0;
    end else begin
      if (load) begin
        op1_q <= Operand1;
        op2_q <= Operand2;
        rm_q  <= RoundMode;
        tag_q <= WA3;
        flg_q <= '0;
      end
      if (state == SPECIAL) begin
        res_q <= spec_res;
        flg_q <= spec_flg;
      end
      if (state == NORM) begin
        res_q <= norm_res;
        flg_q <= norm_flg;
      end
      Done <= (state == DONE);
      if (state == DONE) begin
        Result  <= res_q;
        Flags   <= flg_q;
        FMULWA3 <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_fmul_iter.sv
// Directed bench for fmul_iter: single-precision vectors with hand-computed
// products, latency, handshake, reset abort and STEP variants.
module tb_fmul_iter;

  logic        clk;
  logic        Reset_n;
  logic        Start, start_x;
  logic        RoundMode;
  logic [31:0] Operand1, Operand2;
  logic [3:0]  WA3;

  logic [31:0] Result, Result2, Result4;
  logic [3:0]  Flags, Flags2, Flags4;
  logic        Busy, Busy2, Busy4;
  logic        Done, Done2, Done4;
  logic [3:0]  FMULWA3, Tag2, Tag4;

  int total = 0;
  int bad   = 0;

  fmul_iter #(.EXP_W(8), .MAN_W(23), .STEP(1), .TAG_W(4)) dut (
    .CLK(clk), .Reset_n(Reset_n), .Start(Start), .RoundMode(RoundMode),
    .Operand1(Operand1), .Operand2(Operand2), .WA3(WA3),
    .Result(Result), .Flags(Flags), .Busy(Busy), .Done(Done), .FMULWA3(FMULWA3)
  );

  fmul_iter #(.EXP_W(8), .MAN_W(23), .STEP(2), .TAG_W(4)) dut2 (
    .CLK(clk), .Reset_n(Reset_n), .Start(start_x), .RoundMode(RoundMode),
    .Operand1(Operand1), .Operand2(Operand2), .WA3(WA3),
    .Result(Result2), .Flags(Flags2), .Busy(Busy2), .Done(Done2), .FMULWA3(Tag2)
  );

  fmul_iter #(.EXP_W(8), .MAN_W(23), .STEP(4), .TAG_W(4)) dut4 (
    .CLK(clk), .Reset_n(Reset_n), .Start(start_x), .RoundMode(RoundMode),
    .Operand1(Operand1), .Operand2(Operand2), .WA3(WA3),
    .Result(Result4), .Flags(Flags4), .Busy(Busy4), .Done(Done4), .FMULWA3(Tag4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from just after a clock edge; return cycles until Done is seen
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                        input logic [3:0] tag, output int lat);
    Operand1 = a; Operand2 = b; RoundMode = rm; WA3 = tag; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!Done && lat < 100);
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic rm, input logic [3:0] tag, input logic [31:0] exp_res,
                          input logic [3:0] exp_flg, input int exp_lat);
    int lat;
    run_op(a, b, rm, tag, lat);
    chk({name, "_lat"},   lat,     exp_lat);
    chk({name, "_res"},   Result,  exp_res);
    chk({name, "_flags"}, Flags,   exp_flg);
    chk({name, "_tag"},   FMULWA3, tag);
  endtask

  initial begin
    int lat, n, nd, lat2, lat4;
    logic [31:0] r2, r4;
    logic [3:0]  f2, f4;

    Reset_n = 1'b1; Start = 1'b0; start_x = 1'b0; RoundMode = 1'b0;
    Operand1 = '0; Operand2 = '0; WA3 = '0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_result", Result, 32'h0);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_tag", FMULWA3, 4'h0);
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    @(posedge clk); #1;

    // 1.5 x 2.0
    check_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 1'b0, 4'h5, 32'h40400000, 4'b0000, 26);
    chk("done_busy_low", Busy, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", Done, 1'b0);

    // (1+2^-23)^2: sticky only, both modes truncate
    check_op("sq_rne", 32'h3F800001, 32'h3F800001, 1'b0, 4'h1, 32'h3F800002, 4'b0001, 26);
    check_op("sq_rtz", 32'h3F800001, 32'h3F800001, 1'b1, 4'h2, 32'h3F800002, 4'b0001, 26);

    // (1+2^-23) x 1.5: guard=1, lsb=1 -> RNE rounds up, RTZ truncates
    check_op("rnd_rne", 32'h3F800001, 32'h3FC00000, 1'b0, 4'h3, 32'h3FC00002, 4'b0001, 26);
    check_op("rnd_rtz", 32'h3F800001, 32'h3FC00000, 1'b1, 4'h4, 32'h3FC00001, 4'b0001, 26);

    // Special operands
    check_op("inf_x_zero", 32'h7F800000, 32'h00000000, 1'b0, 4'h6, 32'h7FC00000, 4'b1000, 2);
    check_op("ninf_x_2",   32'hFF800000, 32'h40000000, 1'b0, 4'h7, 32'hFF800000, 4'b0000, 2);
    check_op("snan",       32'h7F800001, 32'h3F800000, 1'b0, 4'h8, 32'h7FC00000, 4'b1000, 2);
    check_op("qnan",       32'hFFC00123, 32'h3F800000, 1'b1, 4'h9, 32'h7FC00000, 4'b0000, 2);
    check_op("nzero_x_2",  32'h80000000, 32'h40000000, 1'b0, 4'hA, 32'h80000000, 4'b0000, 2);
    check_op("subn_ftz",   32'h00000001, 32'hC0000000, 1'b0, 4'hB, 32'h80000000, 4'b0000, 2);

    // Range checks
    check_op("ovf_rne", 32'h7F000000, 32'h7F000000, 1'b0, 4'h1, 32'h7F800000, 4'b0101, 26);
    check_op("ovf_rtz", 32'h7F000000, 32'h7F000000, 1'b1, 4'h2, 32'h7F7FFFFF, 4'b0101, 26);
    check_op("unf",     32'h00800000, 32'h3F000000, 1'b0, 4'h3, 32'h00000000, 4'b0011, 26);

    // Start while busy is ignored
    Operand1 = 32'h3FC00000; Operand2 = 32'h40000000; RoundMode = 1'b0; WA3 = 4'h3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    Operand1 = 32'h7F000000; Operand2 = 32'h7F000000; RoundMode = 1'b1; WA3 = 4'h9; Start = 1'b1;
    chk("ign_busy_mid", Busy, 1'b1);
    @(posedge clk); #1;
    lat++; Start = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!Done && lat < 100);
    chk("ign_lat", lat, 26);
    chk("ign_res", Result, 32'h40400000);
    chk("ign_flags", Flags, 4'b0000);
    chk("ign_tag", FMULWA3, 4'h3);

    // Start in the cycle Busy falls (DONE state) is taken back-to-back
    Operand1 = 32'h3F800001; Operand2 = 32'h3FC00000; RoundMode = 1'b0; WA3 = 4'h6; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; n = 0;
    do begin @(posedge clk); #1; n++; end while (Busy && n < 100);
    chk("b2b_busy_fall", n, 25);
    Operand1 = 32'h3F800001; Operand2 = 32'h3F800001; RoundMode = 1'b0; WA3 = 4'hC; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("b2b_first_done", Done, 1'b1);
    chk("b2b_first_res", Result, 32'h3FC00002);
    chk("b2b_first_tag", FMULWA3, 4'h6);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!Done && lat < 100);
    chk("b2b_second_lat", lat, 26);
    chk("b2b_second_res", Result, 32'h3F800002);
    chk("b2b_second_tag", FMULWA3, 4'hC);

    // Asynchronous reset mid-operation
    Operand1 = 32'h3FC00000; Operand2 = 32'h40000000; RoundMode = 1'b0; WA3 = 4'hA; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("abort_result", Result, 32'h0);
    chk("abort_flags", Flags, 4'h0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_tag", FMULWA3, 4'h0);
    @(posedge clk); #1 Reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (Done) nd++; end
    chk("abort_no_done", nd, 0);
    check_op("after_abort", 32'h3FC00000, 32'h40000000, 1'b0, 4'hD, 32'h40400000, 4'b0000, 26);

    // STEP=2 and STEP=4 variants
    Operand1 = 32'h3F800001; Operand2 = 32'h3F800001; RoundMode = 1'b0; WA3 = 4'hE; start_x = 1'b1;
    @(posedge clk); #1;
    start_x = 1'b0;
    lat2 = 0; lat4 = 0; r2 = '0; r4 = '0; f2 = '0; f4 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (Done2 && lat2 == 0) begin lat2 = i; r2 = Result2; f2 = Flags2; end
      if (Done4 && lat4 == 0) begin lat4 = i; r4 = Result4; f4 = Flags4; end
    end
    chk("step2_lat", lat2, 14);
    chk("step2_res", r2, 32'h3F800002);
    chk("step2_flags", f2, 4'b0001);
    chk("step4_lat", lat4, 8);
    chk("step4_res", r4, 32'h3F800002);
    chk("step4_flags", f4, 4'b0001);
    chk("step4_tag", Tag4, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
